// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared widths, response status codes and sequencer state encoding
package fib_pkg;

    localparam int FIB_DATA_WIDTH  = 64;
    localparam int FIB_ORDER_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_ERR = 2'b01,
        ST_OVF = 2'b10,
        ST_TMO = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_CLEAR = 3'd4,
        S_GAP   = 3'd5
    } state_t;

endpackage

// File: rtl/fib_req_fifo.sv
// rtl/fib_req_fifo.sv - synchronous request FIFO with wrap-bit pointers, no bypass
module fib_req_fifo
    import fib_pkg::*;
#(
    parameter int WIDTH      = FIB_DATA_WIDTH + FIB_ORDER_WIDTH + 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so equal low bits distinguish full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset because empty masks stale entries.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fib_req_sequencer.sv
// rtl/fib_req_sequencer.sv - queues Fibonacci jobs and drives fib_num_gen one job at a time
module fib_req_sequencer
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH  = FIB_DATA_WIDTH,
    parameter int ORDER_WIDTH = FIB_ORDER_WIDTH,
    parameter int TAG_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CLR_CYCLES  = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ORDER_WIDTH-1:0] req_order,
    input  logic [DATA_WIDTH-1:0]  req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   gen_load,
    output logic                   gen_clear,
    output logic [ORDER_WIDTH-1:0] gen_order,
    output logic [DATA_WIDTH-1:0]  gen_data,
    input  logic                   gen_done,
    input  logic                   gen_error,
    input  logic                   gen_overflow,
    input  logic [DATA_WIDTH-1:0]  gen_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic [DATA_WIDTH-1:0]  rsp_result,
    output logic [1:0]             rsp_status,
    output logic                   busy
);

    localparam int ENTRY_W = TAG_WIDTH + ORDER_WIDTH + DATA_WIDTH;

    state_t                 state;
    state_t                 state_nx;
    logic [31:0]            cnt;
    logic                   cnt_clr;
    logic                   pop;
    logic                   capture;
    status_t                cap_status;
    status_t                rsp_status_q;

    logic [TAG_WIDTH-1:0]   cmd_tag;
    logic [ORDER_WIDTH-1:0] cmd_order;
    logic [DATA_WIDTH-1:0]  cmd_data;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     fifo_head;

    // req_ready is forced low while reset is asserted so nothing is accepted into a FIFO being cleared.
    assign req_ready = !fifo_full && !reset;

    fib_req_fifo #(
        .WIDTH      (ENTRY_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid && req_ready),
        .push_data ({req_tag, req_order, req_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Shared cycle counter: WAIT timeout, CLEAR length and GAP length; restarted on each state entry.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // Command registers hold the popped job stable for the whole ISSUE/WAIT window.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_tag   <= '0;
            cmd_order <= '0;
            cmd_data  <= '0;
        end else if (pop) begin
            {cmd_tag, cmd_order, cmd_data} <= fifo_head;
        end
    end

    // Response register captured once per job when WAIT resolves.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_tag      <= '0;
            rsp_result   <= '0;
            rsp_status_q <= ST_OK;
        end else if (capture) begin
            rsp_tag      <= cmd_tag;
            rsp_status_q <= cap_status;
            rsp_result   <= (cap_status == ST_TMO) ? '0 : gen_result;
        end
    end

    // Next-state and generator/response control; status inputs only matter in WAIT.
    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        capture    = 1'b0;
        cap_status = ST_OK;
        cnt_clr    = 1'b0;
        gen_load   = 1'b0;
        gen_clear  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gen_load = 1'b1;
                cnt_clr  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                gen_load = 1'b1;
                if (gen_error) begin
                    capture    = 1'b1;
                    cap_status = ST_ERR;
                    state_nx   = S_RESP;
                end else if (gen_overflow) begin
                    capture    = 1'b1;
                    cap_status = ST_OVF;
                    state_nx   = S_RESP;
                end else if (gen_done) begin
                    capture    = 1'b1;
                    cap_status = ST_OK;
                    state_nx   = S_RESP;
                end else if (cnt == 32'(TIMEOUT - 1)) begin
                    capture    = 1'b1;
                    cap_status = ST_TMO;
                    state_nx   = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                cnt_clr   = 1'b1;
                if (rsp_ready) begin
                    state_nx = (rsp_status_q == ST_OK) ? S_GAP : S_CLEAR;
                end
            end
            S_CLEAR: begin
                gen_clear = 1'b1;
                if (cnt == 32'(CLR_CYCLES - 1)) begin
                    cnt_clr  = 1'b1;
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == 32'(GAP_CYCLES - 1)) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign gen_order  = gen_load ? cmd_order : '0;
    assign gen_data   = gen_load ? cmd_data  : '0;
    assign rsp_status = rsp_status_q;
    assign busy       = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fib_req_sequencer.sv
// tb/tb_fib_req_sequencer.sv - self-checking bench with generator stand-in and Fibonacci scoreboard
module tb_fib_req_sequencer;

    localparam int DW  = 64;
    localparam int OW  = 16;
    localparam int TW  = 8;
    localparam int TMO = 64;
    localparam int CLR = 4;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_order;
    logic [DW-1:0] req_data;
    logic [TW-1:0] req_tag;
    logic          gen_load;
    logic          gen_clear;
    logic [OW-1:0] gen_order;
    logic [DW-1:0] gen_data;
    logic          gen_done;
    logic          gen_error;
    logic          gen_overflow;
    logic [DW-1:0] gen_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] rsp_result;
    logic [1:0]    rsp_status;
    logic          busy;

    always #5 clk = ~clk;

    fib_req_sequencer #(
        .DATA_WIDTH (DW),
        .ORDER_WIDTH(OW),
        .TAG_WIDTH  (TW),
        .FIFO_DEPTH (4),
        .CLR_CYCLES (CLR),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_order   (req_order),
        .req_data    (req_data),
        .req_tag     (req_tag),
        .gen_load    (gen_load),
        .gen_clear   (gen_clear),
        .gen_order   (gen_order),
        .gen_data    (gen_data),
        .gen_done    (gen_done),
        .gen_error   (gen_error),
        .gen_overflow(gen_overflow),
        .gen_result  (gen_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_tag     (rsp_tag),
        .rsp_result  (rsp_result),
        .rsp_status  (rsp_status),
        .busy        (busy)
    );

    typedef struct {
        int            lat;
        logic [OW-1:0] order;
        logic [DW-1:0] seed;
        bit            done;
        bit            err;
        bit            ovf;
        logic [DW-1:0] result;
    } plan_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [1:0]    status;
        logic [DW-1:0] result;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    bit    rdy_cfg;
    bit    rand_mode;
    int    nonok_exp;
    int    clears;
    int    last_load_len;

    plan_t          cur;
    bit             armed;
    int             cd;
    bit             load_prev;
    bit             clr_prev;
    bit             first_load;
    bit             fire_prev;
    bit             hold_prev;
    int             low_run;
    int             clr_run;
    int             load_run;
    logic [OW+DW-1:0]   held_opnd;
    logic [TW+DW+2:0]   held_rsp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Golden sequence x0 = x1 = seed, xn = xn-1 + xn-2; overflow reports the first wrapped term.
    function automatic void fib_model(input int unsigned order, input logic [DW-1:0] seed,
                                      output logic [DW-1:0] res, output bit ovf);
        logic [DW:0]   s;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a   = seed;
        b   = seed;
        ovf = 1'b0;
        res = seed;
        for (int i = 2; i <= int'(order); i++) begin
            s = {1'b0, a} + {1'b0, b};
            a = b;
            b = s[DW-1:0];
            if (s[DW]) begin
                ovf = 1'b1;
                res = b;
                return;
            end
        end
        res = b;
    endfunction

    function automatic logic [1:0] exp_status(input plan_t p);
        if (p.err)       return 2'b01;
        else if (p.ovf)  return 2'b10;
        else if (p.done) return 2'b00;
        else             return 2'b11;
    endfunction

    task automatic push_raw(input logic [OW-1:0] order, input logic [DW-1:0] seed,
                            input logic [TW-1:0] tag, input plan_t p);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_order = order;
        req_data  = seed;
        req_tag   = tag;
        for (int t = 0; t < 1000 && !ok; t++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        chk("push_accepted", 64'(ok), 64'd1);
        if (ok) begin
            p.order  = order;
            p.seed   = seed;
            e.tag    = tag;
            e.status = exp_status(p);
            e.result = (e.status == 2'b11) ? '0 : p.result;
            plan_q.push_back(p);
            exp_q.push_back(e);
            if (e.status != 2'b00) nonok_exp++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_order = '0;
        req_data  = '0;
        req_tag   = '0;
    endtask

    task automatic job(input logic [OW-1:0] order, input logic [DW-1:0] seed,
                       input logic [TW-1:0] tag, input int lat);
        plan_t         p;
        logic [DW-1:0] r;
        bit            o;
        fib_model(order, seed, r, o);
        p.lat = lat;
        if (order == 0 || seed == 0) begin
            p.err = 1'b1; p.ovf = 1'b0; p.done = 1'b0; p.result = '0;
        end else begin
            p.err = 1'b0; p.ovf = o; p.done = !o; p.result = r;
        end
        push_raw(order, seed, tag, p);
    endtask

    task automatic flag_job(input logic [TW-1:0] tag, input logic [2:0] flags, input int lat);
        plan_t p;
        p.lat    = lat;
        p.done   = flags[0];
        p.err    = flags[1];
        p.ovf    = flags[2];
        p.result = {$urandom, $urandom};
        push_raw(16'($urandom_range(1, 500)), {$urandom, $urandom}, tag, p);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && exp_q.size() == 0) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    // Generator stand-in, protocol monitors and response scoreboard, evaluated just after each falling edge.
    task automatic model_loop();
        forever begin
            bit    fire_now;
            bit    rising;
            exp_t  e;
            @(negedge clk);
            #1;
            fire_now = 1'b0;
            if (reset) begin
                gen_done = 1'b0; gen_error = 1'b0; gen_overflow = 1'b0; gen_result = '0;
                armed = 1'b0; load_prev = 1'b0; clr_prev = 1'b0; first_load = 1'b1;
                fire_prev = 1'b0; hold_prev = 1'b0; low_run = 0; clr_run = 0; load_run = 0;
                rsp_ready = rdy_cfg;
            end else begin
                rising = gen_load && !load_prev;
                chk("load_clear_overlap", 64'(gen_load && gen_clear), 64'd0);
                if (!gen_load) chk("operands_zero_when_idle", 64'(|{gen_order, gen_data}), 64'd0);
                if (gen_load && load_prev) chk("operands_stable", 64'({gen_order, gen_data} != held_opnd), 64'd0);
                held_opnd = {gen_order, gen_data};
                if (rising) begin
                    if (!first_load) chk("load_gap_ge2", 64'(low_run >= GAP), 64'd1);
                    first_load = 1'b0;
                    chk("load_has_plan", 64'(plan_q.size() > 0), 64'd1);
                    if (plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                        chk("issue_order", 64'(gen_order), 64'(cur.order));
                        chk("issue_data", gen_data, cur.seed);
                    end else begin
                        cur.done = 1'b0; cur.err = 1'b0; cur.ovf = 1'b0; cur.lat = 1;
                    end
                    armed    = 1'b1;
                    cd       = cur.lat;
                    load_run = 0;
                    low_run  = 0;
                end
                if (gen_load) begin
                    load_run++;
                end else begin
                    if (load_prev) last_load_len = load_run;
                    low_run++;
                end
                if (gen_clear) begin
                    clr_run++;
                end else if (clr_prev) begin
                    chk("clear_length", 64'(clr_run), 64'(CLR));
                    clr_run = 0;
                    clears++;
                end
                if (fire_prev) chk("rsp_latency", 64'(rsp_valid), 64'd1);
                if (hold_prev) chk("rsp_held_stable",
                                   64'({rsp_valid, rsp_tag, rsp_status, rsp_result} != {1'b1, held_rsp[TW+DW+1:0]}), 64'd0);
                rsp_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_cfg;
                hold_prev = rsp_valid && !rsp_ready;
                held_rsp  = {1'b1, rsp_tag, rsp_status, rsp_result};
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                        chk("rsp_status", 64'(rsp_status), 64'(e.status));
                        chk("rsp_result", rsp_result, e.result);
                    end
                end
                if (gen_clear) begin
                    gen_error    = 1'b0;
                    gen_overflow = 1'b0;
                end
                if (!gen_load) begin
                    gen_done = 1'b0;
                    armed    = 1'b0;
                end else if (armed && !rising) begin
                    if (cd <= 1) begin
                        if (cur.done || cur.err || cur.ovf) begin
                            gen_done     = cur.done;
                            gen_error    = cur.err;
                            gen_overflow = cur.ovf;
                            gen_result   = cur.result;
                            fire_now     = 1'b1;
                        end
                        armed = 1'b0;
                    end else begin
                        cd--;
                    end
                end
                fire_prev = fire_now;
                load_prev = gen_load;
                clr_prev  = gen_clear;
            end
        end
    endtask

    initial begin
        int clr_base;
        int nonok_base;
        bit seen;
        reset = 1'b1; req_valid = 1'b0; req_order = '0; req_data = '0; req_tag = '0;
        gen_done = 1'b0; gen_error = 1'b0; gen_overflow = 1'b0; gen_result = '0;
        rsp_ready = 1'b0; rdy_cfg = 1'b1; rand_mode = 1'b0;
        nonok_exp = 0; clears = 0; last_load_len = 0;
        fork
            model_loop();
            begin
                // Reset state
                repeat (2) @(negedge clk);
                chk("reset_req_ready", 64'(req_ready), 64'd0);
                chk("reset_gen_load", 64'(gen_load), 64'd0);
                chk("reset_busy", 64'(busy), 64'd0);
                chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
                reset = 1'b0;
                @(negedge clk);
                chk("post_reset_req_ready", 64'(req_ready), 64'd1);

                // 1: single job, issue latency and result
                job(16'd10, 64'd1, 8'h11, 1);
                chk("t1_load_not_yet", 64'(gen_load), 64'd0);
                @(negedge clk);
                chk("t1_load_at_n2", 64'(gen_load), 64'd1);
                wait_idle("t1_idle");

                // 2: six back-to-back jobs while responses are stalled
                clr_base = clears; nonok_base = nonok_exp;
                rdy_cfg = 1'b0;
                fork
                    begin
                        for (int i = 0; i < 6; i++)
                            job(16'($urandom_range(1, 60)), 64'($urandom_range(1, 1000)), 8'(8'h20 + i), $urandom_range(1, 12));
                    end
                    begin
                        repeat (100) @(negedge clk);
                        chk("t2_ready_low_when_full", 64'(req_ready), 64'd0);
                        chk("t2_accepted_count", 64'(exp_q.size()), 64'd5);
                        chk("t2_busy", 64'(busy), 64'd1);
                        repeat (100) @(negedge clk);
                        rdy_cfg = 1'b1;
                    end
                join
                wait_idle("t2_idle");
                chk("t2_clears", 64'(clears - clr_base), 64'(nonok_exp - nonok_base));

                // 3: zero order reports error and clears, next job still good
                clr_base = clears; nonok_base = nonok_exp;
                job(16'd0, 64'd1, 8'h30, 3);
                job(16'd10, 64'd2, 8'h31, 2);
                wait_idle("t3_idle");
                chk("t3_clears", 64'(clears - clr_base), 64'(nonok_exp - nonok_base));

                // 4: overflow then recovery
                clr_base = clears; nonok_base = nonok_exp;
                job(16'd1500, 64'd1, 8'h40, 5);
                job(16'd15, 64'd1, 8'h41, 1);
                wait_idle("t4_idle");
                chk("t4_clears", 64'(clears - clr_base), 64'(nonok_exp - nonok_base));

                // 5: silent generator hits the timeout
                clr_base = clears; nonok_base = nonok_exp;
                flag_job(8'h50, 3'b000, 1);
                wait_idle("t5_idle");
                chk("t5_load_window", 64'(last_load_len), 64'(1 + TMO));
                chk("t5_clears", 64'(clears - clr_base), 64'(nonok_exp - nonok_base));

                // 6: reset while a queued burst is in WAIT
                for (int i = 0; i < 3; i++) job(16'd20, 64'(i + 1), 8'(8'h60 + i), 12);
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    if (gen_load) seen = 1'b1; else @(negedge clk);
                end
                chk("t6_reached_wait", 64'(seen), 64'd1);
                repeat (3) @(negedge clk);
                reset = 1'b1;
                plan_q.delete();
                exp_q.delete();
                @(negedge clk);
                chk("t6_req_ready_in_reset", 64'(req_ready), 64'd0);
                chk("t6_outputs_zero", 64'(|{gen_load, gen_clear, gen_order, gen_data, rsp_valid, rsp_tag, rsp_status, busy}), 64'd0);
                chk("t6_rsp_result_zero", rsp_result, 64'd0);
                reset = 1'b0;
                @(negedge clk);
                chk("t6_req_ready_after", 64'(req_ready), 64'd1);
                chk("t6_fifo_empty", 64'(busy), 64'd0);
                repeat (40) @(negedge clk);
                chk("t6_no_stale_rsp", 64'(rsp_valid), 64'd0);
                clr_base = clears; nonok_base = nonok_exp;
                job(16'd12, 64'd3, 8'h6a, 2);
                wait_idle("t6_idle");
                chk("t6_clears", 64'(clears - clr_base), 64'(nonok_exp - nonok_base));

                // 7: randomized mix with random response back-pressure
                clr_base = clears; nonok_base = nonok_exp;
                rand_mode = 1'b1;
                for (int i = 0; i < 24; i++) begin
                    if (i % 8 == 7)
                        flag_job(8'($urandom), 3'b000, 1);
                    else if ($urandom_range(0, 2) == 0)
                        flag_job(8'($urandom), 3'($urandom_range(1, 7)), $urandom_range(1, 12));
                    else if ($urandom_range(0, 5) == 0)
                        job(16'($urandom_range(0, 1) ? 0 : 7), 64'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 12));
                    else
                        job(16'($urandom_range(1, 120)), 64'($urandom_range(1, 1000)), 8'($urandom), $urandom_range(1, 12));
                end
                wait_idle("t7_idle");
                rand_mode = 1'b0;
                chk("t7_clears", 64'(clears - clr_base), 64'(nonok_exp - nonok_base));
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
